pixel_ring_buffer: RTL and testbench
====================================

PIXEL_RING_BUFFER -- requirements
Module: pixel_ring_buffer

Interface
REQ-001 Parameter DATA_W, default 8: bits per pixel entry.
REQ-002 Parameter DEPTH, default 72: number of entries in the ring; legal range 2..1024.
REQ-003 Parameter TAPS, default 2: number of read taps; legal range 1..DEPTH.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst  input  1: reset, asynchronous, active-high.
REQ-006 load_valid  input  1: load_data holds a pixel for loading.
REQ-007 load_data  input  DATA_W: pixel value (SPI side).
REQ-008 load_ready  output  1: buffer accepts a load this cycle.
REQ-009 rot_en  input  1: rotate the ring by one entry (network side).
REQ-010 clear  input  1: synchronous frame restart.
REQ-011 rd_data  output  TAPS*DATA_W: tap k occupies bits [k*DATA_W +: DATA_W].
REQ-012 frame_full  output  1: DEPTH entries have been loaded.
REQ-013 count  output  $clog2(DEPTH+1): entries loaded in the current frame.
REQ-014 rot_pos  output  $clog2(DEPTH): rotation offset modulo DEPTH.
REQ-015 wrap  output  1: single-cycle pulse on each completed full revolution.

Function
REQ-016 Storage is a chain of DEPTH entries, stage 0 to stage DEPTH-1; tap k = stage DEPTH-1-k, combinational from registers with zero latency.
REQ-017 FSM states: EMPTY, LOADING, READY; load_ready = 1 in EMPTY and LOADING and 0 in READY.
REQ-018 Accepted load (load_valid & load_ready): stage 0 <= load_data, stage i <= stage i-1, count += 1.
REQ-019 Transitions: EMPTY->LOADING on accepted load with DEPTH>1; LOADING->READY on the accepted load that makes count = DEPTH; frame_full = (state == READY).
REQ-020 In READY, rot_en: stage 0 <= stage DEPTH-1, stage i <= stage i-1, rot_pos += 1 modulo DEPTH.
REQ-021 wrap is registered and asserts for one cycle, in the cycle after the rotation that moves rot_pos from DEPTH-1 to 0.
REQ-022 rot_en outside READY: ignored; no data, rot_pos or wrap change.
REQ-023 load_valid in READY: not accepted; storage and count unchanged.
REQ-024 clear: next state EMPTY, count 0, rot_pos 0, wrap 0; storage contents retained.
REQ-025 Priority when simultaneous: rst > clear > load > rot_en; clear with load_valid discards the load.
REQ-026 count saturates at DEPTH; rot_pos never reaches DEPTH.

Reset
REQ-027 rst asserted: all stages 0, state EMPTY, count 0, rot_pos 0, wrap 0, frame_full 0, load_ready 1, rd_data 0; takes effect immediately, including mid-load and mid-rotation.
REQ-028 First accepted load is possible on the first rising edge after rst deasserts.

Configuration
REQ-029 Macro PIXEL_BUF_OVERRUN_EN defined: adds output overrun (1 bit), set sticky when load_valid=1 and load_ready=0, cleared by clear or rst, reset value 0.
REQ-030 Macro PIXEL_BUF_OVERRUN_EN undefined: overrun port and its logic are absent; all other behaviour is identical.

Structure
REQ-031 Package pixel_buf_pkg holds the state enum (EMPTY, LOADING, READY) and the default constants PIX_W=8, PIX_DEPTH=72, PIX_TAPS=2.
REQ-032 Sub-module pixel_buf_stage: one DATA_W register with shift enable and a 2:1 input select; the top instantiates DEPTH copies in a generate loop.

Verification (DATA_W=8, DEPTH=72, TAPS=2)
REQ-033 Reset, then load 0x00..0x47 back-to-back -> count=72, frame_full=1, load_ready=0, tap0=0x00, tap1=0x01.
REQ-034 From full, 72 rot_en pulses -> after 1 rotation tap0=0x01, tap1=0x02, rot_pos=1; after 72 rotations tap0=0x00, rot_pos=0, wrap high exactly one cycle.
REQ-035 load_valid and rot_en held high for 80 cycles from EMPTY -> exactly 72 loads accepted, no rotation before READY, then rotation each cycle.
REQ-036 clear together with load_valid at count=30 -> count=0, state EMPTY, load discarded, tap values unchanged.
REQ-037 rst asserted mid-frame at count=40, asynchronously between clock edges -> all outputs reach reset values without waiting for a clock edge.
REQ-038 With PIXEL_BUF_OVERRUN_EN, load_valid=1 when full -> overrun=1 and stays 1 until clear.

Source files
------------

// File: rtl/pixel_ring_buffer_pkg.sv
// ---------------------------------------------------------------------------
// pixel_buf_pkg
// Shared definitions for the pixel ring buffer: FSM state encoding and the
// default geometry constants (8-bit pixels, 72-entry ring, 2 read taps).
// Optional feature macro used elsewhere in this slice: PIXEL_BUF_OVERRUN_EN.
// ---------------------------------------------------------------------------
package pixel_buf_pkg;

  localparam int PIX_W     = 8;
  localparam int PIX_DEPTH = 72;
  localparam int PIX_TAPS  = 2;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    READY   = 2'd2
  } buf_state_t;

  // Loads are accepted in every state except READY (frame complete).
  function automatic logic accepts_load(input buf_state_t st);
    return (st != READY);
  endfunction

endpackage

// File: rtl/pixel_ring_buffer_if.sv
// ---------------------------------------------------------------------------
// pixel_ring_buffer_if
// Pixel load channel (SPI side) of the ring buffer.
//   load_valid : master -> slave, load_data holds a pixel
//   load_data  : master -> slave, DATA_W-bit pixel value
//   load_ready : slave -> master, buffer accepts a load this cycle
// ---------------------------------------------------------------------------
interface pixel_ring_buffer_if
  import pixel_buf_pkg::*;
#(
  parameter int DATA_W = PIX_W
);

  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;

  modport master (output load_valid, output load_data, input load_ready);
  modport slave  (input load_valid, input load_data, output load_ready);

endinterface

// File: rtl/pixel_ring_buffer_stage.sv
// ---------------------------------------------------------------------------
// pixel_buf_stage
// One entry of the ring: a DATA_W register that captures one of two inputs
// when shifting is enabled.
//   i_clk, i_rst : clock, asynchronous active-high reset (clears to 0)
//   i_shift_en   : capture the selected input this cycle
//   i_sel_load   : 1 selects i_d_load, 0 selects i_d_rot
//   i_d_load     : input used during a load shift
//   i_d_rot      : input used during a rotation shift
//   o_q          : stored value
// ---------------------------------------------------------------------------
module pixel_buf_stage
  import pixel_buf_pkg::*;
#(
  parameter int DATA_W = PIX_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_shift_en,
  input  logic              i_sel_load,
  input  logic [DATA_W-1:0] i_d_load,
  input  logic [DATA_W-1:0] i_d_rot,
  output logic [DATA_W-1:0] o_q
);

  logic [DATA_W-1:0] r_q;
  logic [DATA_W-1:0] w_d;

  // Input select between load path and rotation path.
  always_comb begin
    if (i_sel_load) begin
      w_d = i_d_load;
    end else begin
      w_d = i_d_rot;
    end
  end

  // Storage register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_shift_en) begin
      r_q <= w_d;
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pixel_ring_buffer.sv
// ---------------------------------------------------------------------------
// pixel_ring_buffer
// Loads a frame of DEPTH pixels through a shift chain, then rotates the full
// ring one entry per rot_en so the network side sees every pixel at the taps.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   load_if      : load channel (slave modport: load_valid/load_data in,
//                  load_ready out)
//   i_rot_en     : rotate the ring by one entry (only honoured when READY)
//   i_clear      : synchronous frame restart; storage is retained
//   o_rd_data    : tap k = stage DEPTH-1-k at bits [k*DATA_W +: DATA_W]
//   o_frame_full : DEPTH entries loaded (state READY)
//   o_count      : entries loaded in the current frame
//   o_rot_pos    : rotation offset modulo DEPTH
//   o_wrap       : one-cycle pulse after each completed revolution
//   o_overrun    : only with PIXEL_BUF_OVERRUN_EN; sticky flag for a load
//                  attempted while load_ready was low
// ---------------------------------------------------------------------------
module pixel_ring_buffer
  import pixel_buf_pkg::*;
#(
  parameter int DATA_W = PIX_W,
  parameter int DEPTH  = PIX_DEPTH,
  parameter int TAPS   = PIX_TAPS
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  pixel_ring_buffer_if.slave           load_if,
  input  logic                         i_rot_en,
  input  logic                         i_clear,
  output logic [TAPS*DATA_W-1:0]       o_rd_data,
  output logic                         o_frame_full,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic [$clog2(DEPTH)-1:0]     o_rot_pos,
  output logic                         o_wrap
`ifdef PIXEL_BUF_OVERRUN_EN
  ,
  output logic                         o_overrun
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int POS_W = $clog2(DEPTH);

  buf_state_t                     r_state;
  logic                           r_load_ready;
  logic                           r_frame_full;
  logic                           r_wrap;
  logic [CNT_W-1:0]               r_count;
  logic [POS_W-1:0]               r_rot_pos;

  logic                           w_load_acc;
  logic                           w_rot;
  logic                           w_shift_en;
  logic                           w_last_load;
  logic                           w_last_pos;
  logic [DEPTH-1:0][DATA_W-1:0]   w_stage;

  // Qualified load/rotate strobes; clear beats load, load beats rotate.
  always_comb begin
    w_load_acc  = load_if.load_valid & r_load_ready & ~i_clear;
    w_rot       = i_rot_en & (r_state == READY) & ~i_clear & ~w_load_acc;
    w_shift_en  = w_load_acc | w_rot;
    w_last_load = (r_count == CNT_W'(DEPTH - 1));
    w_last_pos  = (r_rot_pos == POS_W'(DEPTH - 1));
  end

  // Stage 0 takes the new pixel on a load and the tail entry on a rotate;
  // every other stage takes its predecessor either way.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic [DATA_W-1:0] w_d_load;
    logic [DATA_W-1:0] w_d_rot;
    if (gi == 0) begin : g_head
      assign w_d_load = load_if.load_data;
      assign w_d_rot  = w_stage[DEPTH-1];
    end else begin : g_body
      assign w_d_load = w_stage[gi-1];
      assign w_d_rot  = w_stage[gi-1];
    end
    pixel_buf_stage #(.DATA_W(DATA_W)) u_stage (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_shift_en (w_shift_en),
      .i_sel_load (w_load_acc),
      .i_d_load   (w_d_load),
      .i_d_rot    (w_d_rot),
      .o_q        (w_stage[gi])
    );
  end

  for (genvar gk = 0; gk < TAPS; gk++) begin : g_tap
    assign o_rd_data[gk*DATA_W +: DATA_W] = w_stage[DEPTH-1-gk];
  end

  // Frame FSM with registered status outputs, load counter and rotation offset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= EMPTY;
      r_load_ready <= 1'b1;
      r_frame_full <= 1'b0;
      r_count      <= '0;
      r_rot_pos    <= '0;
      r_wrap       <= 1'b0;
    end else if (i_clear) begin
      r_state      <= EMPTY;
      r_load_ready <= 1'b1;
      r_frame_full <= 1'b0;
      r_count      <= '0;
      r_rot_pos    <= '0;
      r_wrap       <= 1'b0;
    end else begin
      r_wrap <= w_rot & w_last_pos;
      case (r_state)
        EMPTY, LOADING: begin
          if (w_load_acc) begin
            r_count <= r_count + CNT_W'(1);
            if (w_last_load) begin
              r_state      <= READY;
              r_load_ready <= accepts_load(READY);
              r_frame_full <= 1'b1;
            end else begin
              r_state      <= LOADING;
              r_load_ready <= accepts_load(LOADING);
              r_frame_full <= 1'b0;
            end
          end else begin
            r_state <= r_state;
          end
        end
        READY: begin
          if (w_rot) begin
            if (w_last_pos) begin
              r_rot_pos <= '0;
            end else begin
              r_rot_pos <= r_rot_pos + POS_W'(1);
            end
          end else begin
            r_rot_pos <= r_rot_pos;
          end
        end
        default: begin
          r_state      <= EMPTY;
          r_load_ready <= 1'b1;
          r_frame_full <= 1'b0;
          r_count      <= '0;
          r_rot_pos    <= '0;
        end
      endcase
    end
  end

  assign load_if.load_ready = r_load_ready;
  assign o_frame_full       = r_frame_full;
  assign o_count            = r_count;
  assign o_rot_pos          = r_rot_pos;
  assign o_wrap             = r_wrap;

`ifdef PIXEL_BUF_OVERRUN_EN
  logic r_overrun;

  // Sticky overrun: a load offered while the buffer refuses it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_overrun <= 1'b0;
    end else if (i_clear) begin
      r_overrun <= 1'b0;
    end else if (load_if.load_valid & ~r_load_ready) begin
      r_overrun <= 1'b1;
    end else begin
      r_overrun <= r_overrun;
    end
  end

  assign o_overrun = r_overrun;
`endif

endmodule

// File: tb/tb_pixel_ring_buffer.sv
// ---------------------------------------------------------------------------
// tb_pixel_ring_buffer
// Self-checking bench for pixel_ring_buffer (DATA_W=8, DEPTH=72, TAPS=2).
// A behavioural ring model produces the expected outputs for every driven
// cycle; they are queued and compared once the DUT has clocked.
// Build with PIXEL_BUF_OVERRUN_EN defined to also cover the overrun flag.
// ---------------------------------------------------------------------------
module tb_pixel_ring_buffer;

  localparam int DW = 8;
  localparam int DP = 72;
  localparam int TP = 2;

  typedef struct {
    logic [7:0] t0;
    logic [7:0] t1;
    int         cnt;
    int         pos;
    bit         full;
    bit         rdy;
    bit         wrap;
    bit         ovr;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             rot_en = 1'b0;
  logic             clear = 1'b0;
  logic [TP*DW-1:0] rd_data;
  logic             frame_full;
  logic [6:0]       count;
  logic [6:0]       rot_pos;
  logic             wrap;
`ifdef PIXEL_BUF_OVERRUN_EN
  logic             overrun;
`endif

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int acc_cnt = 0;
  int wrap_cnt = 0;

  exp_t sb[$];

  logic [7:0] m_st [DP];
  int m_state;
  int m_cnt;
  int m_pos;
  bit m_wrap;
  bit m_ovr;

  pixel_ring_buffer_if #(.DATA_W(DW)) lif ();

  pixel_ring_buffer #(.DATA_W(DW), .DEPTH(DP), .TAPS(TP)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .load_if      (lif),
    .i_rot_en     (rot_en),
    .i_clear      (clear),
    .o_rd_data    (rd_data),
    .o_frame_full (frame_full),
    .o_count      (count),
    .o_rot_pos    (rot_pos),
    .o_wrap       (wrap)
`ifdef PIXEL_BUF_OVERRUN_EN
    ,
    .o_overrun    (overrun)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DP; i++) m_st[i] = 8'h00;
    m_state = 0;
    m_cnt   = 0;
    m_pos   = 0;
    m_wrap  = 1'b0;
    m_ovr   = 1'b0;
  endtask

  // Next-state of the reference ring for one clock with the given inputs.
  task automatic model_update(input bit lv, input logic [7:0] ld, input bit rot, input bit clr);
    bit rdy;
    logic [7:0] tail;
    rdy = (m_state != 2);
    if (clr) begin
      m_state = 0; m_cnt = 0; m_pos = 0; m_wrap = 1'b0; m_ovr = 1'b0;
    end else begin
      if (lv && !rdy) m_ovr = 1'b1;
      m_wrap = 1'b0;
      if (lv && rdy) begin
        for (int i = DP - 1; i > 0; i--) m_st[i] = m_st[i-1];
        m_st[0] = ld;
        m_cnt++;
        m_state = (m_cnt == DP) ? 2 : 1;
      end else if (rot && m_state == 2) begin
        tail = m_st[DP-1];
        for (int i = DP - 1; i > 0; i--) m_st[i] = m_st[i-1];
        m_st[0] = tail;
        m_wrap = (m_pos == DP - 1);
        m_pos  = (m_pos == DP - 1) ? 0 : m_pos + 1;
      end
    end
  endtask

  task automatic compare_exp(input exp_t e);
    check_eq("tap0", rd_data[7:0], e.t0);
    check_eq("tap1", rd_data[15:8], e.t1);
    check_eq("count", count, e.cnt);
    check_eq("rot_pos", rot_pos, e.pos);
    check_eq("frame_full", frame_full, e.full);
    check_eq("load_ready", lif.load_ready, e.rdy);
    check_eq("wrap", wrap, e.wrap);
`ifdef PIXEL_BUF_OVERRUN_EN
    check_eq("overrun", overrun, e.ovr);
`endif
  endtask

  // Drive one cycle, queue the model's expectation, clock, then score.
  task automatic step(input bit lv, input logic [7:0] ld, input bit rot, input bit clr);
    exp_t e;
    lif.load_valid = lv;
    lif.load_data  = ld;
    rot_en = rot;
    clear  = clr;
    if (lv && lif.load_ready) acc_cnt++;
    model_update(lv, ld, rot, clr);
    e.t0 = m_st[DP-1]; e.t1 = m_st[DP-2];
    e.cnt = m_cnt; e.pos = m_pos;
    e.full = (m_state == 2); e.rdy = (m_state != 2);
    e.wrap = m_wrap; e.ovr = m_ovr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    if (wrap) wrap_cnt++;
    e = sb.pop_front();
    compare_exp(e);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_rd"}, rd_data, 16'h0000);
    check_eq({tag, "_cnt"}, count, 7'd0);
    check_eq({tag, "_pos"}, rot_pos, 7'd0);
    check_eq({tag, "_full"}, frame_full, 1'b0);
    check_eq({tag, "_rdy"}, lif.load_ready, 1'b1);
    check_eq({tag, "_wrap"}, wrap, 1'b0);
`ifdef PIXEL_BUF_OVERRUN_EN
    check_eq({tag, "_ovr"}, overrun, 1'b0);
`endif
  endtask

  initial begin
    logic [7:0] t0_keep;
    logic [7:0] t1_keep;
    lif.load_valid = 1'b0;
    lif.load_data  = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("rst0");
    rst = 1'b0;

    // Back-to-back frame load 0x00..0x47.
    for (int i = 0; i < DP; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    check_eq("full_cnt", count, 7'd72);
    check_eq("full_t0", rd_data[7:0], 8'h00);
    check_eq("full_t1", rd_data[15:8], 8'h01);

    // Load offered while full is refused.
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // One full revolution.
    wrap_cnt = 0;
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("rot1_t0", rd_data[7:0], 8'h01);
    check_eq("rot1_t1", rd_data[15:8], 8'h02);
    check_eq("rot1_pos", rot_pos, 7'd1);
    for (int i = 1; i < DP; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("rev_t0", rd_data[7:0], 8'h00);
    check_eq("rev_pos", rot_pos, 7'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check_eq("wrap_cnt", wrap_cnt, 1);

    // load_valid and rot_en held together from EMPTY.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    acc_cnt = 0;
    for (int i = 0; i < 80; i++) step(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
    check_eq("hold_acc", acc_cnt, 72);
    check_eq("hold_pos", rot_pos, 7'd8);

    // Clear together with a load at count 30.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 30; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    t0_keep = rd_data[7:0];
    t1_keep = rd_data[15:8];
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    check_eq("clr_cnt", count, 7'd0);
    check_eq("clr_t0", rd_data[7:0], t0_keep);
    check_eq("clr_t1", rd_data[15:8], t1_keep);

    // Rotations before READY are ignored.
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset mid-frame at count 40, between clock edges.
    for (int i = 0; i < 40; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    check_eq("pre_rst_cnt", count, 7'd40);
    #3;
    rst = 1'b1;
    #1;
    check_reset_values("arst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    check_eq("post_rst_cnt", count, 7'd1);

    // Fill, then keep offering loads while full.
    for (int i = 1; i < DP; i++) step(1'b1, 8'(i * 3), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'hFF, i[0], 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Randomised mix of loads, rotations and rare clears.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 99) == 0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
